sr_ctrl_multi: RTL and testbench

Parametrised multi-channel serial shift-register configuration controller. It is the successor of the single-channel Top_SR controller. On each start it shifts NCH parallel words of WIDTH bits out to the chip on a shared divided serial clock and simultaneously captures NCH return streams. It then pulses a shared load strobe, presents the captured words, and flags per-channel readback mismatch against the previous write. LVDS buffering stays outside this block; all ports are single-ended.

---
 rtl/sr_ctrl_multi_if.sv | 25 ++
 rtl/sr_ctrl_multi.sv | 206 ++++++++++++++++++++
 tb/tb_sr_ctrl_multi.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_ctrl_multi_if.sv
// Host-side bus of sr_ctrl_multi: transaction request (start/din/div) and result (dout/valid/busy/mismatch).
// The host drives through master; the controller attaches as slave.
interface sr_ctrl_multi_if #(
  parameter int WIDTH     = 170,
  parameter int NCH       = 2,
  parameter int DIV_WIDTH = 6
) ();
  logic                 start;
  logic [NCH*WIDTH-1:0] din;
  logic [DIV_WIDTH-1:0] div;
  logic [NCH*WIDTH-1:0] dout;
  logic                 valid;
  logic                 busy;
  logic [NCH-1:0]       mismatch;

  modport master (
    output start, din, div,
    input  dout, valid, busy, mismatch
  );

  modport slave (
    input  start, din, div,
    output dout, valid, busy, mismatch
  );
endinterface

// File: rtl/sr_ctrl_multi.sv
// Multi-channel serial shift-register configuration controller: shifts NCH words out on a
// shared divided clk_sr, captures the readback streams, pulses load_sr and flags readback mismatch.
module sr_ctrl_multi #(
  parameter int WIDTH           = 170,
  parameter int NCH             = 2,
  parameter int CNT_WIDTH       = 8,
  parameter int DIV_WIDTH       = 6,
  parameter int SHIFT_DIRECTION = 1,
  parameter int LOAD_CYCLES     = 1
) (
  input  logic           clk_in,
  input  logic           rst,
  sr_ctrl_multi_if.slave bus,
  input  logic [NCH-1:0] data_in,
  output logic           clk_sr,
  output logic [NCH-1:0] data_out,
  output logic           load_sr
);

  localparam int TW  = NCH * WIDTH;
  localparam int LCW = (2 * LOAD_CYCLES > 1) ? $clog2(2 * LOAD_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] BIT_LAST  = CNT_WIDTH'(WIDTH);
  localparam logic [LCW-1:0]       LOAD_LAST = LCW'(2 * LOAD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic                 phase_q, phase_d;
  logic [LCW-1:0]       load_cnt_q, load_cnt_d;
  logic [TW-1:0]        sh_q, sh_d;
  logic [TW-1:0]        cap_q, cap_d;
  logic [TW-1:0]        wr_q, wr_d;
  logic [TW-1:0]        shadow_q, shadow_d;
  logic [TW-1:0]        dout_q, dout_d;
  logic [NCH-1:0]       mismatch_q, mismatch_d;
  logic                 valid_q, valid_d;
  logic                 clk_sr_q, clk_sr_d;
  logic                 load_sr_q, load_sr_d;
  logic [NCH-1:0]       data_out_q, data_out_d;

  logic                 tick;
  logic [NCH-1:0]       out_bits;
  logic [TW-1:0]        sh_next;
  logic [TW-1:0]        cap_next;
  logic [NCH-1:0]       mism_vec;

  assign tick = ((state_q == S_SHIFT) || (state_q == S_LOAD)) && (presc_q == div_q);

  // Per-channel bit selection: outgoing bit leaves one end, readback enters the other end.
  always_comb begin
    out_bits = '0;
    sh_next  = '0;
    cap_next = '0;
    mism_vec = '0;
    for (int k = 0; k < NCH; k++) begin
      if (SHIFT_DIRECTION != 0) begin
        out_bits[k]                  = sh_q[k*WIDTH + WIDTH - 1];
        sh_next[k*WIDTH +: WIDTH]    = {sh_q[k*WIDTH +: WIDTH-1], 1'b0};
        cap_next[k*WIDTH +: WIDTH]   = {cap_q[k*WIDTH +: WIDTH-1], data_in[k]};
      end else begin
        out_bits[k]                  = sh_q[k*WIDTH];
        sh_next[k*WIDTH +: WIDTH]    = {1'b0, sh_q[k*WIDTH+1 +: WIDTH-1]};
        cap_next[k*WIDTH +: WIDTH]   = {data_in[k], cap_q[k*WIDTH+1 +: WIDTH-1]};
      end
      mism_vec[k] = (cap_q[k*WIDTH +: WIDTH] != shadow_q[k*WIDTH +: WIDTH]);
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    load_cnt_d = load_cnt_q;
    sh_d       = sh_q;
    cap_d      = cap_q;
    wr_d       = wr_q;
    shadow_d   = shadow_q;
    dout_d     = dout_q;
    mismatch_d = mismatch_q;
    valid_d    = 1'b0;
    clk_sr_d   = clk_sr_q;
    load_sr_d  = load_sr_q;
    data_out_d = data_out_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_SHIFT;
          sh_d      = bus.din;
          wr_d      = bus.din;
          div_d     = bus.div;
          presc_d   = '0;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
          cap_d     = '0;
        end
      end

      // Phase 0 sets up data with clk_sr low; phase 1 raises clk_sr and samples the return line.
      S_SHIFT: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          if (phase_q) begin
            clk_sr_d  = 1'b1;
            cap_d     = cap_next;
            sh_d      = sh_next;
            bit_cnt_d = bit_cnt_q + 1'b1;
            phase_d   = 1'b0;
          end else if (bit_cnt_q == BIT_LAST) begin
            clk_sr_d   = 1'b0;
            data_out_d = '0;
            load_sr_d  = 1'b1;
            load_cnt_d = '0;
            state_d    = S_LOAD;
          end else begin
            clk_sr_d   = 1'b0;
            data_out_d = out_bits;
            phase_d    = 1'b1;
          end
        end
      end

      // Results are committed on the same edge that ends the strobe so valid and dout align.
      S_LOAD: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          if (load_cnt_q == LOAD_LAST) begin
            load_sr_d  = 1'b0;
            state_d    = S_DONE;
            valid_d    = 1'b1;
            dout_d     = cap_q;
            mismatch_d = mism_vec;
            shadow_d   = wr_q;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      phase_q    <= 1'b0;
      load_cnt_q <= '0;
      sh_q       <= '0;
      cap_q      <= '0;
      wr_q       <= '0;
      shadow_q   <= '0;
      dout_q     <= '0;
      mismatch_q <= '0;
      valid_q    <= 1'b0;
      clk_sr_q   <= 1'b0;
      load_sr_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      load_cnt_q <= load_cnt_d;
      sh_q       <= sh_d;
      cap_q      <= cap_d;
      wr_q       <= wr_d;
      shadow_q   <= shadow_d;
      dout_q     <= dout_d;
      mismatch_q <= mismatch_d;
      valid_q    <= valid_d;
      clk_sr_q   <= clk_sr_d;
      load_sr_q  <= load_sr_d;
      data_out_q <= data_out_d;
    end
  end

  assign clk_sr       = clk_sr_q;
  assign load_sr      = load_sr_q;
  assign data_out     = data_out_q;
  assign bus.dout     = dout_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.mismatch = mismatch_q;

endmodule

// File: tb/tb_sr_ctrl_multi.sv
// Bench for sr_ctrl_multi: two 8-bit channels looped back through a shift-register chip model,
// one instance per shift direction; results go through a scoreboard queue.
module tb_sr_ctrl_multi;

  logic clk_in;
  logic rst;

  sr_ctrl_multi_if #(.WIDTH(8), .NCH(2), .DIV_WIDTH(6)) bus_a ();
  sr_ctrl_multi_if #(.WIDTH(8), .NCH(2), .DIV_WIDTH(6)) bus_b ();

  logic       clk_sr_a, load_sr_a, clk_sr_b, load_sr_b;
  logic [1:0] data_out_a, data_in_a, data_out_b, data_in_b;

  sr_ctrl_multi #(
    .WIDTH(8), .NCH(2), .CNT_WIDTH(8), .DIV_WIDTH(6), .SHIFT_DIRECTION(1), .LOAD_CYCLES(1)
  ) dut_a (
    .clk_in(clk_in), .rst(rst), .bus(bus_a), .data_in(data_in_a),
    .clk_sr(clk_sr_a), .data_out(data_out_a), .load_sr(load_sr_a)
  );

  sr_ctrl_multi #(
    .WIDTH(8), .NCH(2), .CNT_WIDTH(8), .DIV_WIDTH(6), .SHIFT_DIRECTION(0), .LOAD_CYCLES(1)
  ) dut_b (
    .clk_in(clk_in), .rst(rst), .bus(bus_b), .data_in(data_in_b),
    .clk_sr(clk_sr_b), .data_out(data_out_b), .load_sr(load_sr_b)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Chip models: MSB-first chip for instance A, LSB-first chip for instance B; preload forces content.
  logic [7:0]  chip_a0, chip_a1, chip_b0, chip_b1;
  logic        preload_a = 1'b0, preload_b = 1'b0;
  logic [15:0] preload_val_a = '0, preload_val_b = '0;

  always @(posedge clk_sr_a or posedge preload_a) begin
    if (preload_a) begin
      chip_a0 <= preload_val_a[7:0];
      chip_a1 <= preload_val_a[15:8];
    end else begin
      chip_a0 <= {chip_a0[6:0], data_out_a[0]};
      chip_a1 <= {chip_a1[6:0], data_out_a[1]};
    end
  end
  assign data_in_a = {chip_a1[7], chip_a0[7]};

  always @(posedge clk_sr_b or posedge preload_b) begin
    if (preload_b) begin
      chip_b0 <= preload_val_b[7:0];
      chip_b1 <= preload_val_b[15:8];
    end else begin
      chip_b0 <= {data_out_b[0], chip_b0[7:1]};
      chip_b1 <= {data_out_b[1], chip_b1[7:1]};
    end
  end
  assign data_in_b = {chip_b1[0], chip_b0[0]};

  int rise_cnt = 0;
  int load_hi  = 0;
  always @(posedge clk_sr_a) rise_cnt <= rise_cnt + 1;
  always @(negedge clk_in) if (load_sr_a === 1'b1) load_hi <= load_hi + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] dout;
    logic [1:0]  mism;
  } sb_item_t;

  sb_item_t   sb[$];
  logic [7:0] chip_word [2];
  logic [7:0] prev_write [2];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin : monitor_a
    sb_item_t e;
    if (bus_a.valid === 1'b1) begin
      checkOutput("sb_pending", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("sb_dout", 64'(bus_a.dout), 64'(e.dout));
        checkOutput("sb_mismatch", 64'(bus_a.mismatch), 64'(e.mism));
      end
    end
  end

  task automatic pushExpect(input logic [7:0] w0, input logic [7:0] w1);
    sb_item_t e;
    e.dout = {chip_word[1], chip_word[0]};
    e.mism = {chip_word[1] != prev_write[1], chip_word[0] != prev_write[0]};
    sb.push_back(e);
    chip_word[0]  = w0;
    chip_word[1]  = w1;
    prev_write[0] = w0;
    prev_write[1] = w1;
  endtask

  task automatic loadChipA(input logic [7:0] p0, input logic [7:0] p1);
    preload_val_a = {p1, p0};
    preload_a = 1'b1;
    #1 preload_a = 1'b0;
    chip_word[0] = p0;
    chip_word[1] = p1;
  endtask

  task automatic loadChipB(input logic [7:0] p0, input logic [7:0] p1);
    preload_val_b = {p1, p0};
    preload_b = 1'b1;
    #1 preload_b = 1'b0;
  endtask

  // Called at a negedge; the next posedge is E0 (n=0). n is the edge after E0 that raised valid.
  task automatic waitValid(input bit drop_start, input int poke_at, output int n, output bit got);
    n   = -1;
    got = 1'b0;
    while (!got && n < 3000) begin
      @(posedge clk_in);
      n++;
      @(negedge clk_in);
      if (poke_at > 0 && n == poke_at) begin
        bus_a.start = 1'b1;
        bus_a.div   = 6'd2;
        bus_a.din   = 16'hDEAD;
      end else if (drop_start) begin
        bus_a.start = 1'b0;
      end
      if (bus_a.valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                               input logic [5:0] d, input int exp_lat, input int poke_at);
    int n;
    bit got;
    int rise0, load0;
    pushExpect(w0, w1);
    rise0 = rise_cnt;
    load0 = load_hi;
    bus_a.din   = {w1, w0};
    bus_a.div   = d;
    bus_a.start = 1'b1;
    waitValid(1'b1, poke_at, n, got);
    checkOutput({tag, "_got_valid"}, 64'(got), 64'd1);
    checkOutput({tag, "_latency"}, 64'(n), 64'(exp_lat));
    checkOutput({tag, "_clk_sr_rises"}, 64'(rise_cnt - rise0), 64'd8);
    checkOutput({tag, "_load_cycles"}, 64'(load_hi - load0), 64'(2 * (int'(d) + 1)));
    checkOutput({tag, "_busy_at_valid"}, 64'(bus_a.busy), 64'd1);
    @(negedge clk_in);
    checkOutput({tag, "_valid_one_cycle"}, 64'(bus_a.valid), 64'd0);
    checkOutput({tag, "_busy_after"}, 64'(bus_a.busy), 64'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, 64'(bus_a.valid), 64'd0);
    checkOutput({tag, "_busy"}, 64'(bus_a.busy), 64'd0);
    checkOutput({tag, "_dout"}, 64'(bus_a.dout), 64'd0);
    checkOutput({tag, "_mismatch"}, 64'(bus_a.mismatch), 64'd0);
    checkOutput({tag, "_clk_sr"}, 64'(clk_sr_a), 64'd0);
    checkOutput({tag, "_load_sr"}, 64'(load_sr_a), 64'd0);
    checkOutput({tag, "_data_out"}, 64'(data_out_a), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  n;
    bit  got;
    logic [7:0] b2b_w [6];

    rst           = 1'b0;
    bus_a.start   = 1'b0;
    bus_a.din     = '0;
    bus_a.div     = '0;
    bus_b.start   = 1'b0;
    bus_b.din     = '0;
    bus_b.div     = '0;
    chip_word[0]  = '0;
    chip_word[1]  = '0;
    prev_write[0] = '0;
    prev_write[1] = '0;

    repeat (3) @(negedge clk_in);
    checkResetState("reset_hold");
    rst = 1'b1;
    @(negedge clk_in);
    loadChipA(8'h00, 8'h00);
    loadChipB(8'h00, 8'h00);

    $display("[TB] basic loopback and readback compare");
    applyStimulus("basic", 8'hA5, 8'h3C, 6'd1, 38, 0);
    applyStimulus("readback", 8'hFF, 8'h3C, 6'd1, 38, 0);
    loadChipA(8'hFF, 8'h3D);
    applyStimulus("forced_ch1", 8'h12, 8'h34, 6'd1, 38, 0);

    $display("[TB] divider settings");
    applyStimulus("div0", 8'h5A, 8'hC3, 6'd0, 19, 0);
    applyStimulus("div63_poke", 8'h0F, 8'hF0, 6'd63, 19 * 64, 200);

    $display("[TB] back-to-back with start held");
    loadChipA(8'h0E, 8'hF0);
    b2b_w[0] = 8'h11; b2b_w[1] = 8'h22;
    b2b_w[2] = 8'h33; b2b_w[3] = 8'h44;
    b2b_w[4] = 8'h55; b2b_w[5] = 8'h66;
    for (int i = 0; i < 3; i++) pushExpect(b2b_w[2*i], b2b_w[2*i+1]);
    bus_a.div   = 6'd1;
    bus_a.din   = {b2b_w[1], b2b_w[0]};
    bus_a.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waitValid(1'b0, 0, n, got);
      checkOutput($sformatf("b2b%0d_got_valid", i), 64'(got), 64'd1);
      checkOutput($sformatf("b2b%0d_latency", i), 64'(n), 64'd38);
      if (i < 2) bus_a.din = {b2b_w[2*i+3], b2b_w[2*i+2]};
      else       bus_a.start = 1'b0;
      @(negedge clk_in);
      checkOutput($sformatf("b2b%0d_gap_busy", i), 64'(bus_a.busy), 64'd0);
      checkOutput($sformatf("b2b%0d_gap_valid", i), 64'(bus_a.valid), 64'd0);
    end
    @(negedge clk_in);
    checkOutput("b2b_stays_idle", 64'(bus_a.busy), 64'd0);

    $display("[TB] reset in the middle of a shift");
    bus_a.din   = 16'h6D5C;
    bus_a.div   = 6'd1;
    bus_a.start = 1'b1;
    @(negedge clk_in);
    bus_a.start = 1'b0;
    repeat (10) @(negedge clk_in);
    checkOutput("mid_busy", 64'(bus_a.busy), 64'd1);
    rst = 1'b0;
    #1;
    checkResetState("async_reset");
    repeat (2) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    checkResetState("after_release");
    prev_write[0] = '0;
    prev_write[1] = '0;
    loadChipA(8'h77, 8'h88);
    applyStimulus("post_reset", 8'h99, 8'hAA, 6'd1, 38, 0);

    $display("[TB] LSB-first instance");
    loadChipB(8'h01, 8'h80);
    bus_b.din   = {8'h80, 8'h01};
    bus_b.div   = 6'd1;
    bus_b.start = 1'b1;
    @(negedge clk_in);
    bus_b.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_in);
      if (clk_sr_b === 1'b1) got = 1'b1;
    end
    checkOutput("dir0_first_rise", 64'(got), 64'd1);
    checkOutput("dir0_first_bit", 64'(data_out_b), 64'b01);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_in);
      if (bus_b.valid === 1'b1) got = 1'b1;
    end
    checkOutput("dir0_got_valid", 64'(got), 64'd1);
    checkOutput("dir0_dout", 64'(bus_b.dout), 64'h8001);
    checkOutput("dir0_mismatch", 64'(bus_b.mismatch), 64'b11);

    repeat (2) @(negedge clk_in);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
